ar_br_operand_dispatcher: RTL

- Upstream feeder for the AR/BR/CR controller-datapath.
- Buffers signed 16-bit operand pairs {AR,BR} in a small FIFO and presents one pair at a time on AR_data/BR_data.
- Drives start and tracks the controller's busy handshake; retires a pair only after busy falls.
- Flags a sticky error when the controller fails to respond within a bounded number of cycles.

---
 rtl/ar_br_operand_dispatcher.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/ar_br_operand_dispatcher.sv
// ---------------------------------------------------------------------------
// ar_br_operand_dispatcher
//
// Purpose:
//   Upstream feeder for the AR/BR/CR controller-datapath. Signed 16-bit
//   operand pairs {AR,BR} are queued in a small FIFO. They are handed to the
//   controller one at a time on AR_data/BR_data with a registered start level.
//   A pair is retired only after the controller has raised busy and then
//   dropped it again. If busy never rises within TIMEOUT cycles of start, a
//   sticky err flag is set, the pair is dropped and dispatch carries on.
//
// Parameters:
//   DEPTH   - FIFO depth in operand pairs (power of two, >= 2)
//   TIMEOUT - cycles start may stay high without busy before erroring (>= 2)
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset, clears all state
//   in_valid   in   operand pair offered
//   in_ready   out  FIFO can accept a pair (not full)
//   in_ar      in   signed AR operand
//   in_br      in   signed BR operand
//   busy       in   busy from the downstream controller
//   start      out  start request to the controller (registered level)
//   AR_data    out  AR operand to the controller
//   BR_data    out  BR operand to the controller
//   pending    out  pairs queued in the FIFO, excluding the one in flight
//   err        out  sticky timeout flag
//   job_count  out  retired-pair counter (only with DISPATCH_COUNT_EN)
//
// Optional build macro:
//   DISPATCH_COUNT_EN - adds the 16-bit job_count output. It counts pairs that
//                       retired normally and wraps. Timed-out pairs are not
//                       counted.
// ---------------------------------------------------------------------------
module ar_br_operand_dispatcher #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [15:0]        in_ar,
    input  logic signed [15:0]        in_br,
    input  logic                      busy,
    output logic                      start,
    output logic signed [15:0]        AR_data,
    output logic signed [15:0]        BR_data,
    output logic [$clog2(DEPTH):0]    pending,
    output logic                      err
`ifdef DISPATCH_COUNT_EN
    ,
    output logic [15:0]               job_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_DONE,
        S_DRAIN
    } state_t;

    // FIFO storage and pointers. The pointers carry one extra wrap bit, so
    // full and empty can be told apart when the index bits are equal.
    logic [31:0]       mem [DEPTH];
    logic [AW:0]       wr_ptr_q;
    logic [AW:0]       rd_ptr_q;
    logic [31:0]       head;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;

    state_t            state_q;
    state_t            state_d;
    logic              start_q;
    logic              start_d;
    logic [TW-1:0]     tmo_q;
    logic [TW-1:0]     tmo_d;
    logic              err_q;
    logic              err_d;
    logic [15:0]       ar_q;
    logic [15:0]       br_q;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // A push is accepted only when the FIFO is not full at this edge. A pop
    // in the same cycle does not free a slot early.
    assign push  = in_valid && !full;
    assign head  = mem[rd_ptr_q[AW-1:0]];

    // Storage needs no reset. Only the pointers define valid contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q[AW-1:0]] <= {in_ar, in_br};
        end
    end

    // Next-state logic for the dispatch FSM.
    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Wait out any busy left over from earlier work before
                // launching the next pair.
                if (!empty && !busy) begin
                    pop     = 1'b1;
                    tmo_d   = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (busy) begin
                    state_d = S_WAIT_DONE;
                end else if (tmo_q == TMO_LAST) begin
                    // This is the TIMEOUT-th cycle of start with no response.
                    err_d   = 1'b1;
                    state_d = S_DRAIN;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_WAIT_DONE: begin
                if (!busy) begin
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        start_d = (state_d == S_ISSUE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            start_q  <= 1'b0;
            tmo_q    <= '0;
            err_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ar_q     <= '0;
            br_q     <= '0;
        end else begin
            state_q  <= state_d;
            start_q  <= start_d;
            tmo_q    <= tmo_d;
            err_q    <= err_d;
            wr_ptr_q <= wr_ptr_q + (AW+1)'(push);
            if (pop) begin
                // The operand registers load only here, so they stay stable
                // for the whole ISSUE/WAIT_DONE handshake.
                ar_q     <= head[31:16];
                br_q     <= head[15:0];
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            end
        end
    end

`ifdef DISPATCH_COUNT_EN
    logic        retire;
    logic [15:0] job_q;

    assign retire = (state_q == S_WAIT_DONE) && !busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            job_q <= '0;
        end else if (retire) begin
            job_q <= job_q + 16'd1;
        end
    end

    assign job_count = job_q;
`endif

    assign in_ready = !full;
    assign start    = start_q;
    assign AR_data  = ar_q;
    assign BR_data  = br_q;
    assign pending  = wr_ptr_q - rd_ptr_q;
    assign err      = err_q;

endmodule
